// File: rtl/note_frame_sender.sv
// note_frame_sender: folds a serial stream of per-bin DFT magnitudes into
// BIN_QTY note bins (saturating) and presents each frame on a held bus.
// Ports: clk, rst (async active-low), binAmp_i/bin_v/ready_o (bin input),
//        noteAmplitudes_o/start/data_v (frame handshake), overrun_o (sticky).
module note_frame_sender #(
  parameter int W       = 6,
  parameter int D       = 10,
  parameter int BIN_QTY = 12,
  parameter int OCTAVES = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [W+D-1:0]                  binAmp_i,
  input  logic                            bin_v,
  output logic                            ready_o,
  output logic [BIN_QTY-1:0][W+D-1:0]     noteAmplitudes_o,
  output logic                            start,
  input  logic                            data_v,
  output logic                            overrun_o
);
  localparam int AW = W + D;
  localparam int NW = (BIN_QTY > 1) ? $clog2(BIN_QTY) : 1;
  localparam int OW = (OCTAVES > 1) ? $clog2(OCTAVES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state;
  logic [AW-1:0]   shadow [BIN_QTY];
  logic [NW-1:0]   note;
  logic [OW-1:0]   oct;
  logic            pend;

  logic            accept;
  logic            last_note;
  logic            last_oct;
  logic [AW:0]     sum;
  logic [AW-1:0]   sat;

  assign ready_o   = ~pend;
  assign accept    = bin_v & ready_o;
  assign last_note = (note == NW'(BIN_QTY - 1));
  assign last_oct  = (oct == OW'(OCTAVES - 1));

  // One extra bit catches the carry; any carry clamps to full scale.
  always_comb begin
    sum = {1'b0, shadow[note]} + {1'b0, binAmp_i};
    sat = sum[AW] ? '1 : sum[AW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      start            <= 1'b0;
      noteAmplitudes_o <= '0;
      note             <= '0;
      oct              <= '0;
      pend             <= 1'b0;
      overrun_o        <= 1'b0;
      for (int i = 0; i < BIN_QTY; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      // Output side: transfer only when a frame is pending, so it
      // never collides with a bin accept (which needs pend=0).
      unique case (state)
        IDLE: begin
          if (pend) begin
            for (int i = 0; i < BIN_QTY; i++) begin
              noteAmplitudes_o[i] <= shadow[i];
            end
            pend  <= 1'b0;
            start <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (data_v) begin
            start <= 1'b0;
            state <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          start <= 1'b0;
          state <= IDLE;
        end
      endcase

      // Input side.
      if (bin_v && !ready_o) begin
        overrun_o <= 1'b1;
      end
      if (accept) begin
        shadow[note] <= (oct == '0) ? binAmp_i : sat;
        if (last_note) begin
          note <= '0;
          if (last_oct) begin
            oct  <= '0;
            pend <= 1'b1;
          end else begin
            oct <= oct + OW'(1);
          end
        end else begin
          note <= note + NW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_note_frame_sender.sv
// tb_note_frame_sender: random + directed stimulus for note_frame_sender
// checked cycle by cycle against a frame-level reference model.
module tb_note_frame_sender;
  localparam int W  = 6;
  localparam int D  = 10;
  localparam int BQ = 12;
  localparam int OC = 2;
  localparam int N  = BQ * OC;

  logic                     clk;
  logic                     rst;
  logic [W+D-1:0]           binAmp_i;
  logic                     bin_v;
  logic                     ready_o;
  logic [BQ-1:0][W+D-1:0]   noteAmplitudes_o;
  logic                     start;
  logic                     data_v;
  logic                     overrun_o;

  note_frame_sender #(
    .W(W), .D(D), .BIN_QTY(BQ), .OCTAVES(OC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .binAmp_i(binAmp_i),
    .bin_v(bin_v),
    .ready_o(ready_o),
    .noteAmplitudes_o(noteAmplitudes_o),
    .start(start),
    .data_v(data_v),
    .overrun_o(overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference model: collects accepted bins of a frame, folds the
  // whole frame arithmetically, and tracks the handshake timing.
  logic [15:0]        fb [N];
  int                 fcnt;
  logic [BQ-1:0][15:0] m_next;
  logic [BQ-1:0][15:0] m_bus;
  bit                 m_pend;
  bit                 m_start;
  bit                 m_gap;
  bit                 m_ovr;

  function automatic logic [BQ-1:0][15:0] fold();
    logic [BQ-1:0][15:0] r;
    for (int n = 0; n < BQ; n++) begin
      int s;
      s = 0;
      for (int o = 0; o < OC; o++) s += int'(fb[o*BQ+n]);
      if (s > 65535) s = 65535;
      r[n] = 16'(s);
    end
    return r;
  endfunction

  task automatic model_clear();
    fcnt = 0; m_next = '0; m_bus = '0;
    m_pend = 0; m_start = 0; m_gap = 0; m_ovr = 0;
  endtask

  task automatic model_edge();
    bit old_pend;
    old_pend = m_pend;
    if (m_start) begin
      if (data_v) begin m_start = 0; m_gap = 1; end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (old_pend) begin
      m_bus = m_next; m_start = 1; m_pend = 0;
    end
    if (bin_v) begin
      if (old_pend) m_ovr = 1;
      else begin
        fb[fcnt] = binAmp_i;
        fcnt++;
        if (fcnt == N) begin
          m_next = fold();
          fcnt = 0;
          m_pend = 1;
        end
      end
    end
  endtask

  task automatic step(input bit bv, input logic [15:0] v, input bit dv);
    bin_v = bv; binAmp_i = v; data_v = dv;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("start", 256'(start), 256'(m_start));
    check("ready", 256'(ready_o), 256'(!m_pend));
    check("overrun", 256'(overrun_o), 256'(m_ovr));
    check("bus", 256'(noteAmplitudes_o), 256'(m_bus));
  endtask

  task automatic do_reset();
    bin_v = 0; data_v = 0; binAmp_i = '0;
    rst = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_start", 256'(start), 256'(0));
    check("rst_bus", 256'(noteAmplitudes_o), 256'(0));
    check("rst_ready", 256'(ready_o), 256'(1));
    check("rst_ovr", 256'(overrun_o), 256'(0));
    rst = 1'b1;
  endtask

  logic [15:0] v;
  int rises;
  bit prev_start;

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b0; bin_v = 0; data_v = 0; binAmp_i = '0;
    model_clear();
    do_reset();

    // Basic fold plus saturation on notes 3 and 4.
    for (int i = 0; i < N; i++) begin
      if (i % BQ == 3) v = 16'hFC00;
      else if (i % BQ == 4) v = 16'h7E00;
      else v = (i < BQ) ? 16'h0400 : 16'h0800;
      step(1, v, 0);
    end
    check("no_start_yet", 256'(start), 256'(0));
    step(0, 0, 0);
    check("start_rise", 256'(start), 256'(1));
    repeat (20) step(0, 0, 0);
    check("hold_start", 256'(start), 256'(1));
    check("note0", 256'(noteAmplitudes_o[0]), 256'(16'h0C00));
    check("note3_sat", 256'(noteAmplitudes_o[3]), 256'(16'hFFFF));
    check("note4", 256'(noteAmplitudes_o[4]), 256'(16'hFC00));
    check("note11", 256'(noteAmplitudes_o[11]), 256'(16'h0C00));

    // Double buffer: second frame streamed while the first is held.
    for (int i = 0; i < N; i++) step(1, 16'($urandom_range(0, 16'h3FFF)), 0);
    check("ready_low", 256'(ready_o), 256'(0));
    step(1, 16'h1234, 0);
    check("overrun_set", 256'(overrun_o), 256'(1));
    step(0, 0, 1);
    check("gap_low", 256'(start), 256'(0));
    step(0, 0, 0);
    check("gap_still_low", 256'(start), 256'(0));
    step(0, 0, 0);
    check("second_start", 256'(start), 256'(1));
    check("ready_back", 256'(ready_o), 256'(1));
    step(0, 0, 1);
    repeat (2) step(0, 0, 0);

    // Reset mid-frame, then a full frame of 1.0 in every bin.
    for (int i = 0; i < 5; i++) step(1, 16'h0FFF, 0);
    do_reset();
    for (int i = 0; i < N; i++) step(1, 16'h0400, 0);
    step(0, 0, 0);
    for (int k = 0; k < BQ; k++)
      check("reset_frame", 256'(noteAmplitudes_o[k]), 256'(16'h0800));
    step(0, 0, 1);

    // Back-to-back: data_v three cycles after each start rise.
    rises = 0;
    prev_start = start;
    for (int c = 0; c < 8 * N && rises < 3; c++) begin
      bit dv;
      dv = 0;
      if (m_start) begin
        step(1, 16'($urandom), 0);
        step(1, 16'($urandom), 0);
        dv = 1;
      end
      step(1, 16'($urandom), dv);
      if (start && !prev_start) rises++;
      prev_start = start;
    end
    check("three_frames", 256'(rises >= 3), 256'(1));

    // Random traffic with random backpressure.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) v = 16'($urandom_range(16'h8000, 16'hFFFF));
      else v = 16'($urandom_range(0, 16'h1FFF));
      step($urandom_range(0, 9) < 8, v, $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
